// File: rtl/adder_pkg.sv
// adder_pkg: definitions shared by the adder16s result path.
//   ENTRY_W    - width of one stored result, {cout, sum}
//   DEPTH_DEF  - default result buffer depth
//   PTR_W_DEF  - default pointer width, log2(DEPTH_DEF)
//   entry_t    - packed {cout, sum} layout, also used by the adder wrapper
package adder_pkg;

  localparam int ENTRY_W   = 17;
  localparam int DEPTH_DEF = 4;
  localparam int PTR_W_DEF = 2;

  typedef struct packed {
    logic        cout;
    logic [15:0] sum;
  } entry_t;

  // Build an entry from the raw adder outputs.
  function automatic entry_t make_entry(input logic cout, input logic [15:0] sum);
    entry_t e;
    e.cout = cout;
    e.sum  = sum;
    return e;
  endfunction

endpackage

// File: rtl/sum_fifo16_if.sv
// sum_fifo16_if: producer/consumer signals of the adder result buffer.
//   in_valid/in_sum/in_cout - adder result presented this cycle
//   out_ready               - consumer accepts the head entry
//   out_valid/out_sum/out_cout - head entry
//   count/full/empty        - occupancy status
//   drop_cnt                - saturating count of results lost while full
// modport master: the adder/consumer side; modport slave: the buffer.
interface sum_fifo16_if #(
  parameter int PTR_W  = 2,
  parameter int DROP_W = 8
) ();

  logic              in_valid;
  logic [15:0]       in_sum;
  logic              in_cout;
  logic              out_ready;
  logic              out_valid;
  logic [15:0]       out_sum;
  logic              out_cout;
  logic [PTR_W:0]    count;
  logic              full;
  logic              empty;
  logic [DROP_W-1:0] drop_cnt;

  modport master (
    output in_valid, in_sum, in_cout, out_ready,
    input  out_valid, out_sum, out_cout, count, full, empty, drop_cnt
  );

  modport slave (
    input  in_valid, in_sum, in_cout, out_ready,
    output out_valid, out_sum, out_cout, count, full, empty, drop_cnt
  );

endinterface

// File: rtl/sum_fifo16_mem.sv
// fifo_mem: DEPTH x ENTRY_W register array for the result buffer.
//   clk   - write clock
//   we    - write enable, waddr/wdata - write port (synchronous)
//   raddr - read address, rdata - read data (asynchronous)
// Storage carries no reset; the top gates the output while empty.
module fifo_mem
  import adder_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int PTR_W = PTR_W_DEF
) (
  input  logic             clk,
  input  logic             we,
  input  logic [PTR_W-1:0] waddr,
  input  entry_t           wdata,
  input  logic [PTR_W-1:0] raddr,
  output entry_t           rdata
);

  entry_t mem_r [DEPTH];

  // Write the incoming entry into the addressed slot.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/sum_fifo16.sv
// sum_fifo16: first-word-fall-through buffer for adder16s results.
//   clk   - system clock, rising edge
//   reset - asynchronous, active-high
//   bus   - sum_fifo16_if slave: result input, valid/ready drain,
//           occupancy flags and saturating drop counter
// An entry pushed at edge N is visible after edge N (no bypass). When full,
// a push is still accepted if the head is popped in the same cycle.
module sum_fifo16
  import adder_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int PTR_W  = PTR_W_DEF,
  parameter int DROP_W = 8
) (
  input  logic        clk,
  input  logic        reset,
  sum_fifo16_if.slave bus
);

  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

  logic [PTR_W-1:0]  rd_ptr_r;
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W:0]    count_r;
  logic [PTR_W:0]    count_nxt_s;
  logic              full_r;
  logic              empty_r;
  logic [DROP_W-1:0] drop_cnt_r;
  logic              pop_s;
  logic              push_s;
  logic              drop_s;
  entry_t            wdata_s;
  entry_t            rdata_s;

  assign pop_s   = !empty_r && bus.out_ready;
  assign push_s  = bus.in_valid && (!full_r || pop_s);
  assign drop_s  = bus.in_valid && full_r && !pop_s;
  assign wdata_s = make_entry(bus.in_cout, bus.in_sum);

  fifo_mem #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_mem (
    .clk   (clk),
    .we    (push_s),
    .waddr (wr_ptr_r),
    .wdata (wdata_s),
    .raddr (rd_ptr_r),
    .rdata (rdata_s)
  );

  // Next occupancy: simultaneous push and pop leave it unchanged.
  always_comb begin
    count_nxt_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + (PTR_W+1)'(1);
      2'b01:   count_nxt_s = count_r - (PTR_W+1)'(1);
      default: count_nxt_s = count_r;
    endcase
  end

  // Pointers, occupancy, flags and drop counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_r   <= '0;
      wr_ptr_r   <= '0;
      count_r    <= '0;
      full_r     <= 1'b0;
      empty_r    <= 1'b1;
      drop_cnt_r <= '0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      count_r <= count_nxt_s;
      // Flags follow the registered count, never pointer comparison.
      full_r  <= (count_nxt_s == DEPTH_C);
      empty_r <= (count_nxt_s == (PTR_W+1)'(0));
      // Saturate rather than wrap so a large loss is never hidden.
      if (drop_s && (drop_cnt_r != {DROP_W{1'b1}})) begin
        drop_cnt_r <= drop_cnt_r + DROP_W'(1);
      end
    end
  end

  assign bus.out_valid = !empty_r;
  // Force zeros while empty so unwritten storage is never exposed.
  assign bus.out_sum   = empty_r ? 16'h0000 : rdata_s.sum;
  assign bus.out_cout  = empty_r ? 1'b0 : rdata_s.cout;
  assign bus.count     = count_r;
  assign bus.full      = full_r;
  assign bus.empty     = empty_r;
  assign bus.drop_cnt  = drop_cnt_r;

endmodule

// File: tb/tb_sum_fifo16.sv
// tb_sum_fifo16: self-checking bench for sum_fifo16. A queue scoreboard
// tracks accepted results; a vector table covers fill and drain; short
// hand-written sequences cover overflow, push+pop when full, wrap, and
// asynchronous reset.
module tb_sum_fifo16;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_fail;
  logic [16:0] q[$];
  logic [7:0]  drop_m;

  sum_fifo16_if #(.PTR_W(2), .DROP_W(8)) bus ();

  sum_fifo16 #(.DEPTH(4), .PTR_W(2), .DROP_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic [15:0] s;
    logic        rdy;
    logic [2:0]  e_count;
    logic        e_full;
    logic        e_valid;
    logic [15:0] e_sum;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus; scoreboard checks head before the edge and
  // status after it. Called just after a falling edge.
  task automatic step(input logic iv, input logic [15:0] s, input logic c, input logic rdy);
    logic popm;
    logic pushm;
    bus.in_valid  = iv;
    bus.in_sum    = s;
    bus.in_cout   = c;
    bus.out_ready = rdy;
    #1;
    chk("valid", {31'd0, bus.out_valid}, (q.size() != 0) ? 32'd1 : 32'd0);
    if (q.size() != 0) begin
      chk("head_sum", {16'd0, bus.out_sum}, {16'd0, q[0][15:0]});
      chk("head_cout", {31'd0, bus.out_cout}, {31'd0, q[0][16]});
    end else begin
      chk("empty_sum", {15'd0, bus.out_cout, bus.out_sum}, 32'd0);
    end
    popm  = (q.size() != 0) && rdy;
    pushm = iv && ((q.size() < 4) || popm);
    @(posedge clk);
    if (popm) void'(q.pop_front());
    if (pushm) q.push_back({c, s});
    if (iv && !pushm && (drop_m != 8'hFF)) drop_m = drop_m + 8'd1;
    @(negedge clk);
    chk("count", {29'd0, bus.count}, 32'(q.size()));
    chk("full", {31'd0, bus.full}, (q.size() == 4) ? 32'd1 : 32'd0);
    chk("empty", {31'd0, bus.empty}, (q.size() == 0) ? 32'd1 : 32'd0);
    chk("drop", {24'd0, bus.drop_cnt}, {24'd0, drop_m});
  endtask

  initial begin
    logic [16:0] ent;
    n_chk  = 0;
    n_fail = 0;
    drop_m = 8'd0;
    bus.in_valid  = 1'b0;
    bus.in_sum    = 16'd0;
    bus.in_cout   = 1'b0;
    bus.out_ready = 1'b0;

    // Fill then drain: expected state after each edge.
    tbl[0] = '{1'b1, 16'd100,  1'b0, 3'd1, 1'b0, 1'b1, 16'd100};
    tbl[1] = '{1'b1, 16'd300,  1'b0, 3'd2, 1'b0, 1'b1, 16'd100};
    tbl[2] = '{1'b1, 16'd600,  1'b0, 3'd3, 1'b0, 1'b1, 16'd100};
    tbl[3] = '{1'b1, 16'd1000, 1'b0, 3'd4, 1'b1, 1'b1, 16'd100};
    tbl[4] = '{1'b0, 16'd0,    1'b1, 3'd3, 1'b0, 1'b1, 16'd300};
    tbl[5] = '{1'b0, 16'd0,    1'b1, 3'd2, 1'b0, 1'b1, 16'd600};
    tbl[6] = '{1'b0, 16'd0,    1'b1, 3'd1, 1'b0, 1'b1, 16'd1000};
    tbl[7] = '{1'b0, 16'd0,    1'b1, 3'd0, 1'b0, 1'b0, 16'd0};

    // Reset, then idle.
    reset = 1'b1;
    #1;
    chk("rst_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_empty", {31'd0, bus.empty}, 32'd1);
    chk("rst_full", {31'd0, bus.full}, 32'd0);
    chk("rst_count", {29'd0, bus.count}, 32'd0);
    chk("rst_drop", {24'd0, bus.drop_cnt}, 32'd0);
    chk("rst_sum", {15'd0, bus.out_cout, bus.out_sum}, 32'd0);
    #19;
    reset = 1'b0;
    for (int i = 0; i < 5; i++) step(1'b0, 16'd0, 1'b0, 1'b0);

    // Table-driven fill and drain.
    for (int i = 0; i < 8; i++) begin
      step(tbl[i].iv, tbl[i].s, 1'b0, tbl[i].rdy);
      chk("tbl_count", {29'd0, bus.count}, {29'd0, tbl[i].e_count});
      chk("tbl_full", {31'd0, bus.full}, {31'd0, tbl[i].e_full});
      chk("tbl_valid", {31'd0, bus.out_valid}, {31'd0, tbl[i].e_valid});
      chk("tbl_sum", {16'd0, bus.out_sum}, {16'd0, tbl[i].e_sum});
    end

    // Push and pop together while full.
    step(1'b1, 16'd100,  1'b0, 1'b0);
    step(1'b1, 16'd300,  1'b0, 1'b0);
    step(1'b1, 16'd600,  1'b0, 1'b0);
    step(1'b1, 16'd1000, 1'b0, 1'b0);
    step(1'b1, 16'hFFFF, 1'b1, 1'b1);
    chk("pp_count", {29'd0, bus.count}, 32'd4);
    chk("pp_drop", {24'd0, bus.drop_cnt}, 32'd0);
    chk("pp_head", {16'd0, bus.out_sum}, 32'd300);
    for (int i = 0; i < 3; i++) step(1'b0, 16'd0, 1'b0, 1'b1);
    chk("pp_last_sum", {16'd0, bus.out_sum}, 32'hFFFF);
    chk("pp_last_cout", {31'd0, bus.out_cout}, 32'd1);
    step(1'b0, 16'd0, 1'b0, 1'b1);

    // Streaming with one push and one pop per cycle across pointer wrap.
    step(1'b1, 16'd1, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      ent = 17'(32'd1000 * 32'(i + 2));
      if (i == 4) ent = 17'h08000 + 17'h08000;
      step(1'b1, ent[15:0], ent[16], 1'b1);
      chk("wrap_count", {29'd0, bus.count}, 32'd1);
      if (i == 4) begin
        chk("carry_sum", {16'd0, bus.out_sum}, 32'd0);
        chk("carry_cout", {31'd0, bus.out_cout}, 32'd1);
      end
    end
    step(1'b0, 16'd0, 1'b0, 1'b1);

    // Overflow and saturation of the drop counter.
    step(1'b1, 16'd100,  1'b0, 1'b0);
    step(1'b1, 16'd300,  1'b0, 1'b0);
    step(1'b1, 16'd600,  1'b0, 1'b0);
    step(1'b1, 16'd1000, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 16'd7, 1'b1, 1'b0);
    chk("ovf_drop3", {24'd0, bus.drop_cnt}, 32'd3);
    chk("ovf_head", {16'd0, bus.out_sum}, 32'd100);
    for (int i = 0; i < 300; i++) step(1'b1, 16'd9, 1'b0, 1'b0);
    chk("ovf_sat", {24'd0, bus.drop_cnt}, 32'd255);
    chk("ovf_count", {29'd0, bus.count}, 32'd4);

    // Asynchronous reset with three entries stored.
    bus.in_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    q.delete();
    drop_m = 8'd0;
    step(1'b1, 16'd11, 1'b0, 1'b0);
    step(1'b1, 16'd12, 1'b0, 1'b0);
    step(1'b1, 16'd13, 1'b0, 1'b0);
    chk("pre_rst_count", {29'd0, bus.count}, 32'd3);
    #2;
    reset = 1'b1;
    #1;
    chk("async_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("async_count", {29'd0, bus.count}, 32'd0);
    chk("async_full", {31'd0, bus.full}, 32'd0);
    chk("async_sum", {16'd0, bus.out_sum}, 32'd0);
    q.delete();
    @(negedge clk);
    reset = 1'b0;
    step(1'b1, 16'd42, 1'b0, 1'b0);
    chk("post_rst_sum", {16'd0, bus.out_sum}, 32'd42);
    step(1'b0, 16'd0, 1'b0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
